lut_match_prog: RTL and testbench
=================================

LUT_MATCH_PROG -- requirements
Module: lut_match_prog

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the code width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the number of table entries (>=2).
REQ-003 The module SHALL have parameter AW, default $clog2(DEPTH), giving the entry index width.
REQ-004 The module SHALL have port clk, input, width 1, carrying the single clock (all logic on its rising edge).
REQ-005 The module SHALL have port rst, input, width 1, carrying the reset, which is asynchronous and active-high.
REQ-006 The module SHALL have port in_valid, input, width 1, qualifying the lookup code.
REQ-007 The module SHALL have port in_data, input, width WIDTH, carrying the lookup code.
REQ-008 The module SHALL have port out_valid, output, width 1, qualifying the registered result.
REQ-009 The module SHALL have port out_hit, output, width 1, indicating that the code matched a valid entry.
REQ-010 The module SHALL have port out_idx, output, width AW, giving the matching entry index (0 on miss).
REQ-011 The module SHALL have port wr_en, input, width 1, requesting a table write.
REQ-012 The module SHALL have port wr_addr, input, width AW, giving the entry to write.
REQ-013 The module SHALL have port wr_data, input, width WIDTH, giving the code to store.
REQ-014 The module SHALL have port wr_vld, input, width 1, giving the valid bit to store with the entry (0 disables it).
REQ-015 The module SHALL have port wr_ready, output, width 1, and a write SHALL be accepted only when wr_en and wr_ready are both high.
REQ-016 The module SHALL have port clr_all, input, width 1, a single-cycle request to invalidate all entries.
REQ-017 The module SHALL have port busy, output, width 1, high while the clear sweep runs.

Function
REQ-018 Lookup latency SHALL be exactly 1 cycle: out_valid(n+1)=in_valid(n); out_hit and out_idx SHALL be updated only when in_valid is high and SHALL hold otherwise.
REQ-019 A hit SHALL require entry valid and an exact WIDTH-bit match; on multiple hits the lowest index SHALL win.
REQ-020 On a write and a lookup in the same cycle, the lookup SHALL see the table contents before the write.
REQ-021 Writes with wr_addr >= DEPTH SHALL be accepted and ignored.
REQ-022 The FSM SHALL have states IDLE and SWEEP; in IDLE wr_ready=1 and busy=0.
REQ-023 In IDLE, clr_all=1 SHALL move the FSM to SWEEP with the sweep pointer at 0; a write in that same cycle SHALL still be applied.
REQ-024 In SWEEP, the FSM SHALL clear one entry valid bit per cycle (index 0..DEPTH-1), hold wr_ready=0 and busy=1, and ignore clr_all.
REQ-025 The FSM SHALL return to IDLE after clearing entry DEPTH-1, so busy is high for exactly DEPTH cycles.
REQ-026 Lookups SHALL continue during SWEEP against the partially cleared table.

Reset
REQ-027 While rst is high, the entries SHALL load the package default codes with all valid bits set.
REQ-028 While rst is high, the FSM SHALL be in IDLE and the sweep pointer at 0.
REQ-029 While rst is high, out_valid, out_hit, out_idx and busy SHALL be 0 and wr_ready SHALL be 1.
REQ-030 Reset asserted mid-SWEEP SHALL abort the sweep and restore the defaults.

Configuration
REQ-031 With macro LUT_MATCH_HIT_CNT_EN defined, the module SHALL add output hit_cnt, width 16, a saturating count (at 16'hFFFF) of registered hits.
REQ-032 hit_cnt SHALL clear on reset and on entry to SWEEP.
REQ-033 Without LUT_MATCH_HIT_CNT_EN, the hit_cnt port and the counter logic SHALL be absent.

Structure
REQ-034 Shared package lut_pkg SHALL hold the FSM state enum (IDLE, SWEEP) and the default-code array function; for WIDTH=4, DEPTH=4 the defaults SHALL be {4'h1, 4'h0, 4'h5, 4'h8}, with unlisted entries 0 and invalid.
REQ-035 Sub-module lut_match_cmp SHALL be a purely combinational priority comparator (table, valid bits, code -> hit, idx) instantiated once.

Verification
REQ-036 After reset, lookups 5, 8, 0, 1, 7 SHALL return hit/idx 1/2, 1/3, 1/1, 1/0, 0/0, each 1 cycle later.
REQ-037 Writing addr 2 = 4'h9 (vld=1) with a simultaneous lookup of 5 SHALL return hit=1 idx=2; a next-cycle lookup of 5 SHALL miss and a lookup of 9 SHALL give idx=2.
REQ-038 Writing addr 0 = 4'h8 then looking up 8 SHALL return idx=0 (priority).
REQ-039 clr_all SHALL give busy high for 4 cycles with wr_en ignored; a lookup of 8 on sweep cycle 2 SHALL hit and all lookups after the sweep SHALL miss.
REQ-040 rst pulsed on sweep cycle 2 SHALL give busy=0 and a subsequent lookup of 5 SHALL return idx=2.
REQ-041 With LUT_MATCH_HIT_CNT_EN defined, 3 hits and 1 miss SHALL give hit_cnt=3, clr_all SHALL give hit_cnt=0, and a preload near saturation SHALL stick at 16'hFFFF.

Source files
------------

// File: rtl/lut_pkg.sv
// Shared types and reset defaults for the programmable match table.
package lut_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    localparam int unsigned NumDefaults = 4;

    // Reset code for entry idx; entries past the listed defaults reset to 0.
    function automatic logic [31:0] default_code(input int unsigned idx);
        logic [31:0] code;
        case (idx)
            0:       code = 32'h1;
            1:       code = 32'h0;
            2:       code = 32'h5;
            3:       code = 32'h8;
            default: code = 32'h0;
        endcase
        return code;
    endfunction

    function automatic logic default_vld(input int unsigned idx);
        return idx < NumDefaults;
    endfunction

endpackage

// File: rtl/lut_match_cmp.sv
// Combinational priority comparator: lowest valid matching entry wins.
module lut_match_cmp #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] codes,
    input  logic [DEPTH-1:0]            vld,
    input  logic [WIDTH-1:0]            code,
    output logic                        hit,
    output logic [AW-1:0]               idx
);

    // Scan from the top so the lowest matching index is the last to assign.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (vld[i] && (codes[i] == code)) begin
                hit = 1'b1;
                idx = AW'(i);
            end
        end
    end

endmodule

// File: rtl/lut_match_prog.sv
// Programmable exact-match lookup table with a one-entry-per-cycle clear sweep.
// Optional saturating hit counter enabled by LUT_MATCH_HIT_CNT_EN.
module lut_match_prog
    import lut_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic             out_hit,
    output logic [AW-1:0]    out_idx,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_vld,
    output logic             wr_ready,
    input  logic             clr_all,
`ifdef LUT_MATCH_HIT_CNT_EN
    output logic [15:0]      hit_cnt,
`endif
    output logic             busy
);

    state_e state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    logic [DEPTH-1:0][WIDTH-1:0] codes_q, codes_d, codes_rst;
    logic [DEPTH-1:0]            vld_q, vld_d, vld_rst;

    logic          out_valid_q, out_valid_d;
    logic          out_hit_q, out_hit_d;
    logic [AW-1:0] out_idx_q, out_idx_d;

    logic          cmp_hit;
    logic [AW-1:0] cmp_idx;
    logic          wr_fire;
    logic          sweep_start;

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            codes_rst[i] = WIDTH'(default_code(i));
            vld_rst[i]   = default_vld(i);
        end
    end

    // Lookup sees the registered table, i.e. contents before any same-cycle write.
    lut_match_cmp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_cmp (
        .codes (codes_q),
        .vld   (vld_q),
        .code  (in_data),
        .hit   (cmp_hit),
        .idx   (cmp_idx)
    );

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (clr_all) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        wr_ready = (state_q == IDLE);
        busy     = (state_q == SWEEP);
    end

    assign wr_fire     = wr_en && wr_ready;
    assign sweep_start = (state_q == IDLE) && clr_all;

    // Table update: writes only land in IDLE, sweep clears one valid bit per cycle.
    always_comb begin
        codes_d = codes_q;
        vld_d   = vld_q;
        if (wr_fire && (32'(wr_addr) < DEPTH)) begin
            codes_d[wr_addr] = wr_data;
            vld_d[wr_addr]   = wr_vld;
        end
        if (busy) begin
            vld_d[ptr_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            codes_q <= codes_rst;
            vld_q   <= vld_rst;
        end else begin
            codes_q <= codes_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        out_valid_d = in_valid;
        out_hit_d   = out_hit_q;
        out_idx_d   = out_idx_q;
        if (in_valid) begin
            out_hit_d = cmp_hit;
            out_idx_d = cmp_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_hit_q   <= out_hit_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_hit   = out_hit_q;
    assign out_idx   = out_idx_q;

`ifdef LUT_MATCH_HIT_CNT_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;

    // Clearing on sweep entry takes priority over a hit in the same cycle.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (sweep_start) begin
            hit_cnt_d = '0;
        end else if (in_valid && cmp_hit && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_lut_match_prog.sv
// Scoreboard bench for lut_match_prog with a behavioural table model.
// Hit counter checks are compiled in when LUT_MATCH_HIT_CNT_EN is defined.
module tb_lut_match_prog;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid, out_hit;
    logic [AW-1:0]    out_idx;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             wr_vld = 1'b0;
    logic             wr_ready;
    logic             clr_all = 1'b0;
    logic             busy;
`ifdef LUT_MATCH_HIT_CNT_EN
    logic [15:0]      hit_cnt;
`endif

    lut_match_prog #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_hit   (out_hit),
        .out_idx   (out_idx),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_vld    (wr_vld),
        .wr_ready  (wr_ready),
        .clr_all   (clr_all),
`ifdef LUT_MATCH_HIT_CNT_EN
        .hit_cnt   (hit_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          hit;
        logic [AW-1:0] idx;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Behavioural model: table contents, sweep progress, hit count.
    int m_code[DEPTH];
    bit m_vld[DEPTH];
    bit m_sweep;
    int m_next_clear;
    int m_cnt;
    logic          last_hit;
    logic [AW-1:0] last_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_lookup(input int code);
        exp_t e;
        e.hit = 1'b0;
        e.idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_vld[i] && m_code[i] == code) begin
                e.hit = 1'b1;
                e.idx = AW'(i);
                return e;
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        m_code[0] = 1; m_code[1] = 0; m_code[2] = 5; m_code[3] = 8;
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b1;
        m_sweep = 1'b0;
        m_next_clear = 0;
        m_cnt = 0;
        last_hit = 1'b0;
        last_idx = '0;
        q.delete();
    endtask

    // One clock cycle of stimulus, entered and left #1 after a rising edge.
    task automatic cycle(input bit lv, input int ld, input bit we, input int wa,
                         input int wd, input bit wv, input bit clr);
        exp_t e;
        chk("busy", busy, m_sweep);
        chk("wr_ready", wr_ready, !m_sweep);
`ifdef LUT_MATCH_HIT_CNT_EN
        chk("hit_cnt", hit_cnt, m_cnt);
`endif
        in_valid = lv;
        in_data  = WIDTH'(ld);
        wr_en    = we;
        wr_addr  = AW'(wa);
        wr_data  = WIDTH'(wd);
        wr_vld   = wv;
        clr_all  = clr;
        e = model_lookup(ld);
        if (lv) q.push_back(e);
        @(posedge clk);
        if (lv && e.hit && m_cnt < 65535) m_cnt++;
        if (m_sweep) begin
            m_vld[m_next_clear] = 1'b0;
            m_next_clear++;
            if (m_next_clear == DEPTH) m_sweep = 1'b0;
        end else begin
            if (we && wa < DEPTH) begin
                m_code[wa] = wd;
                m_vld[wa]  = wv;
            end
            if (clr) begin
                m_sweep = 1'b1;
                m_next_clear = 0;
                m_cnt = 0;
            end
        end
        #1;
    endtask

    task automatic look(input int code);
        cycle(1'b1, code, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        in_valid = 1'b0; wr_en = 1'b0; clr_all = 1'b0;
        model_reset();
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_hit", out_hit, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ready", wr_ready, 1);
`ifdef LUT_MATCH_HIT_CNT_EN
        chk("rst_hit_cnt", hit_cnt, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard on each valid result, checks hold otherwise.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("lookup_hit", out_hit, e.hit);
                    chk("lookup_idx", out_idx, e.idx);
                    last_hit = e.hit;
                    last_idx = e.idx;
                end
            end else begin
                chk("hold_hit", out_hit, last_hit);
                chk("hold_idx", out_idx, last_idx);
            end
        end
    end

    initial begin
        model_reset();
        #1;
        apply_reset();

        // Default table lookups
        look(5); look(8); look(0); look(1); look(7);

        // Write collides with lookup: lookup sees old table
        cycle(1'b1, 5, 1'b1, 2, 9, 1'b1, 1'b0);
        look(5); look(9);

        // Duplicate code at a lower index wins
        cycle(1'b0, 0, 1'b1, 0, 8, 1'b1, 1'b0);
        look(8);

        // Clear sweep with writes attempted throughout; lookup 8 on sweep cycle 2
        cycle(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
        cycle(1'b0, 0, 1'b1, 1, 8, 1'b1, 1'b1);
        cycle(1'b1, 8, 1'b1, 3, 8, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 2, 5, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b1, 3, 8, 1'b1, 1'b0);
        look(8); look(5); look(9); look(0); look(1);
        idle_cycle();

        // Reset on sweep cycle 2 aborts and restores defaults
        cycle(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
        idle_cycle();
        apply_reset();
        look(5);
        idle_cycle();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            bit lv, we, wv, clr;
            int ld, wa, wd;
            lv  = 1'($urandom_range(0, 3) != 0);
            ld  = int'($urandom_range(0, 15));
            we  = 1'($urandom_range(0, 3) == 0);
            wa  = int'($urandom_range(0, DEPTH - 1));
            wd  = int'($urandom_range(0, 15));
            wv  = 1'($urandom_range(0, 4) != 0);
            clr = 1'($urandom_range(0, 39) == 0);
            cycle(lv, ld, we, wa, wd, wv, clr);
        end
        idle_cycle();

`ifdef LUT_MATCH_HIT_CNT_EN
        apply_reset();
        look(5); look(8); look(7); look(1);
        idle_cycle();
        chk("hit_cnt_three", hit_cnt, 3);
        cycle(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
        chk("hit_cnt_clr", hit_cnt, 0);
        for (int i = 0; i < DEPTH; i++) idle_cycle();
        apply_reset();
        for (int i = 0; i < 65540; i++) look(5);
        idle_cycle();
        chk("hit_cnt_sat", hit_cnt, 16'hFFFF);
`endif

        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
